// File: rtl/fio_init_sequencer_if.sv
// Bus bundle for fio_init_sequencer: host word stream, BRAM init write port,
// MEM read port and dump stream. master = sequencer side, slave = environment side.
interface fio_init_sequencer_if #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 256,
  parameter int ADDR_W = 10
) ();
  logic              host_valid;
  logic              host_ready;
  logic [DATA_W-1:0] host_data;

  logic [NUM_CH-1:0] ch_wen;
  logic [ADDR_W-1:0] ch_addr;
  logic [DATA_W-1:0] ch_wdata;

  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;

  logic              dump_valid;
  logic              dump_ready;
  logic [DATA_W-1:0] dump_data;
  logic              dump_last;

  modport master (
    input  host_valid, host_data, rd_data, dump_ready,
    output host_ready, ch_wen, ch_addr, ch_wdata, rd_en, rd_addr,
           dump_valid, dump_data, dump_last
  );

  modport slave (
    output host_valid, host_data, rd_data, dump_ready,
    input  host_ready, ch_wen, ch_addr, ch_wdata, rd_en, rd_addr,
           dump_valid, dump_data, dump_last
  );
endinterface

// File: rtl/fio_init_sequencer.sv
// FileIO engine: streams host words into the BRAM init channels, releases the GPU,
// waits for finished, then dumps a MEM window. FIO_LOAD_CKSUM_EN adds load_cksum.
module fio_init_sequencer #(
  parameter int                   NUM_CH       = 4,
  parameter int                   DATA_W       = 256,
  parameter int                   ADDR_W       = 10,
  parameter logic [16*NUM_CH-1:0] CH_DEPTH_VEC = {16'd256, 16'd256, 16'd512, 16'd1024},
  parameter int                   DUMP_BASE    = 1,
  parameter int                   DUMP_LEN     = 16,
  parameter int                   RD_LAT       = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 go,
  fio_init_sequencer_if.master bus,
  output logic                 clear_o,
  output logic                 start_o,
  input  logic                 finished_i,
  output logic                 busy,
  output logic                 done
`ifdef FIO_LOAD_CKSUM_EN
  ,
  output logic [DATA_W-1:0]    load_cksum
`endif
);

  localparam int                CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int                DC_W      = (DUMP_LEN > 1) ? $clog2(DUMP_LEN) : 1;
  localparam logic [DC_W-1:0]   DUMP_LAST = DC_W'(DUMP_LEN - 1);
  localparam logic [2:0]        LAT_LAST  = 3'(RD_LAT - 1);
  localparam logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(DUMP_BASE);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_CLEAR, S_RUN, S_DRD, S_DWAIT, S_DOUT, S_DONE
  } state_t;

  state_t              state_reg, state_next;
  logic [CH_W-1:0]     ch_reg, ch_next;
  logic [15:0]         cnt_reg, cnt_next;
  logic [DC_W-1:0]     dcnt_reg, dcnt_next;
  logic [2:0]          lat_reg, lat_next;
  logic [NUM_CH-1:0]   wen_reg, wen_next;
  logic [ADDR_W-1:0]   waddr_reg, waddr_next;
  logic [DATA_W-1:0]   wdata_reg, wdata_next;
  logic [DATA_W-1:0]   dump_data_reg, dump_data_next;
`ifdef FIO_LOAD_CKSUM_EN
  logic [DATA_W-1:0]   cksum_reg, cksum_next;
`endif

  logic [15:0]         ch_depth [NUM_CH];
  logic                first_found, next_found;
  logic [CH_W-1:0]     first_ch, next_ch;
  logic                last_word;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_depth
      assign ch_depth[gi] = CH_DEPTH_VEC[16*gi +: 16];
    end
  endgenerate

  // Descending scan so the lowest qualifying index wins; zero-depth channels are skipped.
  always_comb begin
    first_found = 1'b0;
    first_ch    = '0;
    next_found  = 1'b0;
    next_ch     = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (ch_depth[i] != 16'd0) begin
        first_found = 1'b1;
        first_ch    = CH_W'(i);
        if (i > int'(ch_reg)) begin
          next_found = 1'b1;
          next_ch    = CH_W'(i);
        end
      end
    end
  end

  assign last_word = (cnt_reg == ch_depth[ch_reg] - 16'd1);

  always_comb begin
    state_next     = state_reg;
    ch_next        = ch_reg;
    cnt_next       = cnt_reg;
    dcnt_next      = dcnt_reg;
    lat_next       = lat_reg;
    wen_next       = '0;
    waddr_next     = waddr_reg;
    wdata_next     = wdata_reg;
    dump_data_next = dump_data_reg;
`ifdef FIO_LOAD_CKSUM_EN
    cksum_next     = cksum_reg;
`endif
    case (state_reg)
      S_IDLE, S_DONE: begin
        if (go) begin
          ch_next    = first_ch;
          cnt_next   = '0;
          state_next = first_found ? S_LOAD : S_CLEAR;
`ifdef FIO_LOAD_CKSUM_EN
          cksum_next = '0;
`endif
        end
      end
      S_LOAD: begin
        if (bus.host_valid) begin
          wen_next[ch_reg] = 1'b1;
          waddr_next       = cnt_reg[ADDR_W-1:0];
          wdata_next       = bus.host_data;
`ifdef FIO_LOAD_CKSUM_EN
          cksum_next       = cksum_reg ^ bus.host_data;
`endif
          if (last_word) begin
            cnt_next = '0;
            if (next_found) ch_next = next_ch;
            else            state_next = S_CLEAR;
          end else begin
            cnt_next = cnt_reg + 16'd1;
          end
        end
      end
      S_CLEAR: state_next = S_RUN;
      S_RUN: begin
        if (finished_i) begin
          dcnt_next  = '0;
          state_next = S_DRD;
        end
      end
      S_DRD: begin
        lat_next   = '0;
        state_next = S_DWAIT;
      end
      // rd_data becomes valid in the RD_LAT-th cycle after the strobe.
      S_DWAIT: begin
        if (lat_reg == LAT_LAST) begin
          dump_data_next = bus.rd_data;
          state_next     = S_DOUT;
        end else begin
          lat_next = lat_reg + 3'd1;
        end
      end
      S_DOUT: begin
        if (bus.dump_ready) begin
          if (dcnt_reg == DUMP_LAST) begin
            state_next = S_DONE;
          end else begin
            dcnt_next  = dcnt_reg + 1'b1;
            state_next = S_DRD;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= S_IDLE;
      ch_reg        <= '0;
      cnt_reg       <= '0;
      dcnt_reg      <= '0;
      lat_reg       <= '0;
      wen_reg       <= '0;
      waddr_reg     <= '0;
      wdata_reg     <= '0;
      dump_data_reg <= '0;
`ifdef FIO_LOAD_CKSUM_EN
      cksum_reg     <= '0;
`endif
    end else begin
      state_reg     <= state_next;
      ch_reg        <= ch_next;
      cnt_reg       <= cnt_next;
      dcnt_reg      <= dcnt_next;
      lat_reg       <= lat_next;
      wen_reg       <= wen_next;
      waddr_reg     <= waddr_next;
      wdata_reg     <= wdata_next;
      dump_data_reg <= dump_data_next;
`ifdef FIO_LOAD_CKSUM_EN
      cksum_reg     <= cksum_next;
`endif
    end
  end

  assign bus.host_ready = (state_reg == S_LOAD);
  assign bus.ch_wen     = wen_reg;
  assign bus.ch_addr    = waddr_reg;
  assign bus.ch_wdata   = wdata_reg;
  assign bus.rd_en      = (state_reg == S_DRD);
  assign bus.rd_addr    = BASE_ADDR + ADDR_W'(dcnt_reg);
  assign bus.dump_valid = (state_reg == S_DOUT);
  assign bus.dump_data  = dump_data_reg;
  assign bus.dump_last  = (state_reg == S_DOUT) && (dcnt_reg == DUMP_LAST);
  assign clear_o        = (state_reg == S_CLEAR);
  assign start_o        = (state_reg == S_RUN);
  assign busy           = (state_reg != S_IDLE) && (state_reg != S_DONE);
  assign done           = (state_reg == S_DONE);
`ifdef FIO_LOAD_CKSUM_EN
  assign load_cksum     = cksum_reg;
`endif

endmodule

// File: tb/tb_fio_init_sequencer.sv
// Randomized self-checking bench for fio_init_sequencer: load/run/dump sessions
// compared against a queue-based reference model and a delayed-read MEM model.
module tb_fio_init_sequencer;
  localparam int NUM_CH    = 4;
  localparam int DATA_W    = 256;
  localparam int ADDR_W    = 10;
  localparam int DUMP_BASE = 1;
  localparam int DUMP_LEN  = 16;
  localparam int RD_LAT    = 3;
  localparam logic [16*NUM_CH-1:0] DEPTH_VEC = {16'd3, 16'd0, 16'd2, 16'd4};
  localparam int DEPTH [NUM_CH] = '{4, 2, 0, 3};

  logic clk_tb = 1'b0;
  logic rst_n, go, finished_i;
  logic clear_o, start_o, busy, done;
`ifdef FIO_LOAD_CKSUM_EN
  logic [DATA_W-1:0] load_cksum;
`endif
  int tests_run = 0;
  int tests_failed = 0;

  logic [DATA_W-1:0] mem [1 << ADDR_W];
  logic [ADDR_W-1:0] pipe_addr [RD_LAT];
  logic              pipe_v    [RD_LAT];

  fio_init_sequencer_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bif ();

  fio_init_sequencer #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .CH_DEPTH_VEC(DEPTH_VEC),
    .DUMP_BASE(DUMP_BASE), .DUMP_LEN(DUMP_LEN), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk_tb), .rst_n(rst_n), .go(go), .bus(bif.master),
    .clear_o(clear_o), .start_o(start_o), .finished_i(finished_i),
    .busy(busy), .done(done)
`ifdef FIO_LOAD_CKSUM_EN
    , .load_cksum(load_cksum)
`endif
  );

  always #5 clk_tb = ~clk_tb;

  // MEM model: data for a strobe in cycle t is presented during cycle t+RD_LAT only.
  always @(posedge clk_tb or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_v[i]    <= 1'b0;
        pipe_addr[i] <= '0;
      end
    end else begin
      pipe_v[0]    <= bif.rd_en;
      pipe_addr[0] <= bif.rd_addr;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_v[i]    <= pipe_v[i-1];
        pipe_addr[i] <= pipe_addr[i-1];
      end
    end
  end
  assign bif.rd_data = pipe_v[RD_LAT-1] ? mem[pipe_addr[RD_LAT-1]] : '0;

  function automatic logic [DATA_W-1:0] rand_word();
    logic [DATA_W-1:0] r;
    for (int j = 0; j < DATA_W / 32; j++) r[32*j +: 32] = $urandom();
    return r;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; go = 1'b0; finished_i = 1'b0;
    bif.host_valid = 1'b0; bif.host_data = '0; bif.dump_ready = 1'b0;
    repeat (3) @(negedge clk_tb);
    rst_n = 1'b1;
    @(negedge clk_tb);
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0 || clear_o !== 1'b0 || start_o !== 1'b0 || bif.host_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: busy=%b done=%b clear=%b start=%b host_ready=%b, expected all 0", busy, done, clear_o, start_o, bif.host_ready);
    end
    tests_run++;
    if (bif.ch_wen !== '0 || bif.ch_addr !== '0 || bif.ch_wdata !== '0 || bif.rd_en !== 1'b0 || bif.rd_addr !== ADDR_W'(DUMP_BASE)
        || bif.dump_valid !== 1'b0 || bif.dump_last !== 1'b0 || bif.dump_data !== '0) begin
      tests_failed++;
      $display("FAIL reset_bus: wen=%b addr=%0d rd_en=%b rd_addr=%0d dvalid=%b dlast=%b, expected zeros (rd_addr=%0d)",
               bif.ch_wen, bif.ch_addr, bif.rd_en, bif.rd_addr, bif.dump_valid, bif.dump_last, DUMP_BASE);
    end
  endtask

  // mode 0: valid always, data 1..N, finished_i glitch; 1: valid toggles; 2: random; 3: checksum pattern
  task automatic test_load(input int mode);
    logic [DATA_W-1:0] data_q[$];
    int                ch_q[$];
    int                addr_q[$];
    logic [DATA_W-1:0] pat [3];
    logic [DATA_W-1:0] exp_ck, p_data, d;
    logic [NUM_CH-1:0] exp_wen;
    int                idx, cyc, p_ch, p_addr;
    bit                pend, v;
    pat[0] = 'hA5; pat[1] = 'h5A; pat[2] = 'hFF;
    exp_ck = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      for (int a = 0; a < DEPTH[ch]; a++) begin
        if (mode <= 1)      d = DATA_W'(ch_q.size() + 1);
        else if (mode == 3) d = pat[ch_q.size() % 3];
        else                d = rand_word();
        ch_q.push_back(ch); addr_q.push_back(a); data_q.push_back(d);
        exp_ck ^= d;
      end
    end
    go = 1'b1;
    @(negedge clk_tb);
    go = 1'b0;
    tests_run++;
    if (bif.host_ready !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL load_entry: host_ready=%b busy=%b done=%b, expected 1 1 0", bif.host_ready, busy, done);
    end
    idx = 0; cyc = 0; pend = 1'b0; p_ch = 0; p_addr = 0; p_data = '0;
    for (int guard = 0; guard < 500; guard++) begin
      exp_wen = '0;
      if (pend) exp_wen[p_ch] = 1'b1;
      tests_run++;
      if (bif.ch_wen !== exp_wen || (pend && (bif.ch_addr !== ADDR_W'(p_addr) || bif.ch_wdata !== p_data))) begin
        tests_failed++;
        $display("FAIL load_write: wen=%b addr=%0d data=%h, expected wen=%b addr=%0d data=%h",
                 bif.ch_wen, bif.ch_addr, bif.ch_wdata, exp_wen, p_addr, p_data);
      end
      if (idx == ch_q.size()) break;
      tests_run++;
      if (bif.host_ready !== 1'b1 || clear_o !== 1'b0 || start_o !== 1'b0) begin
        tests_failed++;
        $display("FAIL load_state: host_ready=%b clear=%b start=%b, expected 1 0 0", bif.host_ready, clear_o, start_o);
      end
      cyc++;
      if (mode == 1)      v = (cyc % 2) == 1;
      else if (mode == 2) v = $urandom_range(0, 1) == 1;
      else                v = 1'b1;
      bif.host_valid = v;
      bif.host_data  = v ? data_q[idx] : rand_word();
      finished_i     = (mode == 0 && cyc == 2);
      pend = v;
      if (v) begin
        p_ch = ch_q[idx]; p_addr = addr_q[idx]; p_data = data_q[idx];
        idx++;
      end
      @(negedge clk_tb);
    end
    finished_i = 1'b0;
    bif.host_valid = 1'b1;
    bif.host_data  = rand_word();
    tests_run++;
    if (clear_o !== 1'b1 || start_o !== 1'b0 || bif.host_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL clear_pulse: clear=%b start=%b host_ready=%b, expected 1 0 0", clear_o, start_o, bif.host_ready);
    end
`ifdef FIO_LOAD_CKSUM_EN
    tests_run++;
    if (load_cksum !== exp_ck) begin
      tests_failed++;
      $display("FAIL cksum: load_cksum=%h, expected %h", load_cksum, exp_ck);
    end
`endif
    @(negedge clk_tb);
    bif.host_valid = 1'b0;
    tests_run++;
    if (clear_o !== 1'b0 || start_o !== 1'b1 || bif.host_ready !== 1'b0 || bif.ch_wen !== '0) begin
      tests_failed++;
      $display("FAIL run_entry: clear=%b start=%b host_ready=%b wen=%b, expected 0 1 0 0", clear_o, start_o, bif.host_ready, bif.ch_wen);
    end
`ifdef FIO_LOAD_CKSUM_EN
    tests_run++;
    if (load_cksum !== exp_ck) begin
      tests_failed++;
      $display("FAIL cksum_hold: load_cksum=%h, expected %h", load_cksum, exp_ck);
    end
`endif
  endtask

  // mode 0: MEM[k]=k*0x11 with 5 stall cycles per word; 1: random MEM and stalls
  task automatic test_run_dump(input int mode);
    int nst, a;
    for (int k = 0; k < (1 << ADDR_W); k++) mem[k] = (mode == 0) ? DATA_W'(k * 17) : rand_word();
    go = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_tb);
      go = 1'b0;
      tests_run++;
      if (start_o !== 1'b1 || bif.rd_en !== 1'b0 || bif.host_ready !== 1'b0 || busy !== 1'b1) begin
        tests_failed++;
        $display("FAIL run_hold: start=%b rd_en=%b host_ready=%b busy=%b, expected 1 0 0 1", start_o, bif.rd_en, bif.host_ready, busy);
      end
    end
    finished_i = 1'b1;
    @(negedge clk_tb);
    finished_i = 1'b0;
    for (int k = 0; k < DUMP_LEN; k++) begin
      a = (DUMP_BASE + k) % (1 << ADDR_W);
      tests_run++;
      if (bif.rd_en !== 1'b1 || bif.rd_addr !== ADDR_W'(a) || start_o !== 1'b0 || bif.dump_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL dump_rd: rd_en=%b rd_addr=%0d start=%b dvalid=%b, expected 1 %0d 0 0", bif.rd_en, bif.rd_addr, start_o, bif.dump_valid, a);
      end
      for (int w = 0; w < RD_LAT; w++) begin
        bif.dump_ready = (mode == 1) ? ($urandom_range(0, 1) == 1) : 1'b0;
        @(negedge clk_tb);
        tests_run++;
        if (bif.rd_en !== 1'b0 || bif.dump_valid !== 1'b0) begin
          tests_failed++;
          $display("FAIL dump_wait: rd_en=%b dvalid=%b at wait cycle %0d, expected 0 0", bif.rd_en, bif.dump_valid, w);
        end
      end
      bif.dump_ready = 1'b0;
      @(negedge clk_tb);
      tests_run++;
      if (bif.dump_valid !== 1'b1 || bif.dump_data !== mem[a] || bif.dump_last !== (k == DUMP_LEN - 1)) begin
        tests_failed++;
        $display("FAIL dump_word %0d: dvalid=%b last=%b data=%h, expected 1 %0d %h", k, bif.dump_valid, bif.dump_last, bif.dump_data, k == DUMP_LEN - 1, mem[a]);
      end
      nst = (mode == 0) ? 5 : $urandom_range(0, 3);
      for (int s = 0; s < nst; s++) begin
        @(negedge clk_tb);
        tests_run++;
        if (bif.dump_valid !== 1'b1 || bif.dump_data !== mem[a] || bif.dump_last !== (k == DUMP_LEN - 1)) begin
          tests_failed++;
          $display("FAIL dump_stall %0d: dvalid=%b last=%b data=%h, expected 1 %0d %h", k, bif.dump_valid, bif.dump_last, bif.dump_data, k == DUMP_LEN - 1, mem[a]);
        end
      end
      bif.dump_ready = 1'b1;
      @(negedge clk_tb);
      bif.dump_ready = 1'b0;
    end
    tests_run++;
    if (done !== 1'b1 || busy !== 1'b0 || bif.dump_valid !== 1'b0 || start_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL dump_done: done=%b busy=%b dvalid=%b start=%b, expected 1 0 0 0", done, busy, bif.dump_valid, start_o);
    end
    @(negedge clk_tb);
    tests_run++;
    if (done !== 1'b1 || bif.rd_en !== 1'b0) begin
      tests_failed++;
      $display("FAIL done_hold: done=%b rd_en=%b, expected 1 0", done, bif.rd_en);
    end
  endtask

  task automatic test_reset_mid_load();
    go = 1'b1;
    @(negedge clk_tb);
    go = 1'b0;
    for (int w = 0; w < 3; w++) begin
      bif.host_valid = 1'b1;
      bif.host_data  = DATA_W'(w + 1);
      @(negedge clk_tb);
    end
    tests_run++;
    if (bif.ch_wen !== 4'b0001 || bif.ch_addr !== ADDR_W'(2) || bif.ch_wdata !== DATA_W'(3)) begin
      tests_failed++;
      $display("FAIL mid_pre: wen=%b addr=%0d data=%h, expected 0001 2 3", bif.ch_wen, bif.ch_addr, bif.ch_wdata);
    end
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if (bif.ch_wen !== '0 || bif.ch_addr !== '0 || bif.ch_wdata !== '0 || bif.host_ready !== 1'b0 || busy !== 1'b0
        || done !== 1'b0 || clear_o !== 1'b0 || start_o !== 1'b0 || bif.rd_en !== 1'b0 || bif.dump_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_reset: wen=%b addr=%0d host_ready=%b busy=%b done=%b clear=%b start=%b, expected all 0",
               bif.ch_wen, bif.ch_addr, bif.host_ready, busy, done, clear_o, start_o);
    end
    bif.host_valid = 1'b0;
    @(negedge clk_tb);
    rst_n = 1'b1;
    @(negedge clk_tb);
    tests_run++;
    if (busy !== 1'b0 || bif.host_ready !== 1'b0 || bif.ch_wen !== '0) begin
      tests_failed++;
      $display("FAIL mid_idle: busy=%b host_ready=%b wen=%b, expected 0 0 0", busy, bif.host_ready, bif.ch_wen);
    end
  endtask

  task automatic test_back_to_back();
    test_load(1);
    test_run_dump(1);
  endtask

  initial begin
    test_reset();
    test_load(0);
    test_run_dump(0);
    test_back_to_back();
    test_reset_mid_load();
    test_load(2);
    test_run_dump(1);
`ifdef FIO_LOAD_CKSUM_EN
    test_load(3);
    test_run_dump(1);
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit, tests_failed=%0d", tests_failed);
    $fatal(1, "watchdog expired");
  end
endmodule
